// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough to hold the value n, so a count up to n never wraps.
    function automatic int counter_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the serial adder's bit-slice datapath.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one bit per clock, LSB first, through a single full adder.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed-overflow output V.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic         V
`endif
);

    localparam int CW = counter_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          carry;
    logic [CW-1:0] count;
    logic          fa_sum;
    logic          fa_cout;
    logic [N-1:0]  s_next;

    full_adder u_full_adder (
        .A    (a_reg[0]),
        .B    (b_reg[0]),
        .Cin  (carry),
        .S    (fa_sum),
        .Cout (fa_cout)
    );

    // The new sum bit enters at the MSB, so after N shifts bit 0 sits at S[0].
    always_comb begin
        s_next        = S >> 1;
        s_next[N-1]   = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            carry <= 1'b0;
            count <= '0;
            a_reg <= '0;
            b_reg <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            V     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= Cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> 1;
                    b_reg <= b_reg >> 1;
                    carry <= fa_cout;
                    S     <= s_next;
                    count <= count + CW'(1);
                    // Last bit: the carry flop still holds the carry into the MSB.
                    if (count == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        V     <= carry ^ fa_cout;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, random N=8 operations
// against an arithmetic model, and an exhaustive N=4 sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic       busy8, done8, cout8;
    logic [7:0] s8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4, cout4;
    logic [3:0] s4;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic       v8, v4;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .A     (a8),
        .B     (b8),
        .Cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .S     (s8),
        .Cout  (cout8)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .V     (v8)
`endif
    );

    serial_adder #(.N(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .A     (a4),
        .B     (b4),
        .Cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .S     (s4),
        .Cout  (cout4)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .V     (v4)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic logic [8:0] refSum8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int total;
        total = int'(a) + int'(b) + int'(cin);
        return 9'(total);
    endfunction

    function automatic logic refOverflow8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int signedTotal;
        signedTotal = int'($signed(a)) + int'($signed(b)) + int'(cin);
        return (signedTotal > 127) || (signedTotal < -128);
    endfunction

    // Starts one N=8 operation and returns the number of edges until done is seen.
    // glitchAt > 0 pulses start with other operands on that RUN cycle.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                 input int glitchAt, output int latency);
        @(negedge clk);
        a8 = a;
        b8 = b;
        cin8 = cin;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        latency = 1;
        while (done8 !== 1'b1 && latency < 40) begin
            if (latency == glitchAt) begin
                a8 = ~a;
                b8 = ~b;
                cin8 = ~cin;
                start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            latency++;
        end
        start8 = 1'b0;
    endtask

    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                  output int latency);
        @(negedge clk);
        a4 = a;
        b4 = b;
        cin4 = cin;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        latency = 1;
        while (done4 !== 1'b1 && latency < 30) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic checkResult8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] expected;
        expected = refSum8(a, b, cin);
        checkOutput({tag, "_sum"}, {23'd0, cout8, s8}, {23'd0, expected});
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput({tag, "_v"}, v8, refOverflow8(a, b, cin));
`endif
    endtask

    initial begin
        int latency;
        int gap;
        logic sawDone;
        logic [7:0] ra, rb;
        logic rc;
        logic [4:0] expected4;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy8, 1'b0);
        checkOutput("reset_done", done8, 1'b0);
        checkOutput("reset_s", s8, 8'h00);
        checkOutput("reset_cout", cout8, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput("reset_v", v8, 1'b0);
`endif
        rst = 1'b0;

        // Full carry ripple: FF + 01.
        applyStimulus(8'hFF, 8'h01, 1'b0, 0, latency);
        checkOutput("ff01_latency", latency, 9);
        checkOutput("ff01_s", s8, 8'h00);
        checkOutput("ff01_cout", cout8, 1'b1);
        @(negedge clk);
        checkOutput("ff01_done_pulse", done8, 1'b0);
        checkOutput("ff01_s_hold", s8, 8'h00);
        checkOutput("ff01_cout_hold", cout8, 1'b1);
        checkOutput("ff01_idle_busy", busy8, 1'b0);

        applyStimulus(8'h7F, 8'h01, 1'b0, 0, latency);
        checkOutput("7f01_s", s8, 8'h80);
        checkOutput("7f01_cout", cout8, 1'b0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput("7f01_v", v8, 1'b1);
`endif
        applyStimulus(8'h05, 8'h03, 1'b0, 0, latency);
        checkOutput("0503_s", s8, 8'h08);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checkOutput("0503_v", v8, 1'b0);
`endif

        // Start pulsed during RUN cycle 3 must not disturb the running operation.
        applyStimulus(8'h3C, 8'h5A, 1'b1, 3, latency);
        checkOutput("ignore_latency", latency, 9);
        checkResult8("ignore", 8'h3C, 8'h5A, 1'b1);
        @(negedge clk);
        checkOutput("ignore_no_restart", busy8, 1'b0);

        // Reset on RUN cycle 4 discards the operation.
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("run_busy", busy8, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", busy8, 1'b0);
        checkOutput("midrst_done", done8, 1'b0);
        checkOutput("midrst_s", s8, 8'h00);
        checkOutput("midrst_cout", cout8, 1'b0);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) sawDone = 1'b1;
        end
        checkOutput("midrst_no_done", sawDone, 1'b0);
        applyStimulus(8'h9C, 8'h27, 1'b0, 0, latency);
        checkOutput("after_rst_latency", latency, 9);
        checkResult8("after_rst", 8'h9C, 8'h27, 1'b0);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        latency = 0;
        while (done8 !== 1'b1 && latency < 40) begin
            @(negedge clk);
            latency++;
        end
        checkOutput("b2b_first_latency", latency, 9);
        checkResult8("b2b_first", 8'h12, 8'h34, 1'b0);
        a8 = 8'hC8; b8 = 8'h64; cin8 = 1'b1;
        @(negedge clk);
        gap = 1;
        checkOutput("b2b_no_idle", busy8, 1'b1);
        start8 = 1'b0;
        while (done8 !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("b2b_period", gap, 9);
        checkResult8("b2b_second", 8'hC8, 8'h64, 1'b1);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, 0, latency);
            checkOutput("rand_latency", latency, 9);
            checkResult8("rand", ra, rb, rc);
        end

        // Exhaustive N=4 sweep.
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    applyStimulus4(4'(a), 4'(b), 1'(c), latency);
                    expected4 = 5'(a + b + c);
                    checkOutput("n4_sum", {cout4, s4}, expected4);
                    checkOutput("n4_latency", latency, 5);
                end
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: N, 8, operand width in bits (N >= 1).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin an addition.
REQ-005 SHALL have port: A  input  N  first operand, sampled on accepted start.
REQ-006 SHALL have port: B  input  N  second operand, sampled on accepted start.
REQ-007 SHALL have port: Cin  input  1  carry-in, sampled on accepted start.
REQ-008 SHALL have port: busy  output  1  high while bits are being processed.
REQ-009 SHALL have port: done  output  1  single-cycle pulse when the result becomes valid.
REQ-010 SHALL have port: S  output  N  sum, valid from the done pulse onward.
REQ-011 SHALL have port: Cout  output  1  final carry-out, valid from the done pulse onward.
REQ-012 SHALL have port, only when SERIAL_ADDER_OVERFLOW_EN is defined: V  output  1  signed two's-complement overflow.

Function
REQ-013 SHALL implement the states IDLE, RUN and DONE.
REQ-014 SHALL accept start in IDLE or DONE: load A and B into shift registers, load Cin into the carry flop, clear the bit counter, then go to RUN.
REQ-015 SHALL process exactly one bit per cycle in RUN, LSB first: A[0], B[0] and the carry flop go into the full adder, the sum bit shifts into S from the MSB, and the carry flop takes the adder's carry-out.
REQ-016 SHALL leave RUN after N RUN cycles, enter DONE, and assert done for exactly that one cycle.
- Latency: start sampled at edge t, done high during cycle t+N+1.
REQ-017 SHALL hold S and Cout (and V) stable from the done pulse until the next accepted start.
REQ-018 SHALL make S and Cout equal to the low N bits and bit N of A+B+Cin.
REQ-019 SHALL drive busy=1 exactly in RUN; start while busy SHALL be ignored, with no change to operands or progress.
REQ-020 SHALL move from DONE to IDLE on the cycle after done if start is low; start high in DONE SHALL begin a new operation immediately (back-to-back).
REQ-021 SHALL size the bit counter to ceil(log2(N+1)) bits so the counter never wraps before reaching N; N=1 SHALL complete in one RUN cycle.
REQ-022 SHALL give rst priority over start when both are high.

Reset
REQ-023 SHALL, when rst is high at a clock edge, enter IDLE and clear busy, done, S, Cout, V, the carry flop, the counter and the shift registers.
REQ-024 SHALL discard any RUN operation interrupted by reset, with no done pulse.

Configuration
REQ-025 SHALL, with SERIAL_ADDER_OVERFLOW_EN defined, provide V = carry into bit N-1 XOR carry out of bit N-1, captured at the last RUN cycle.
REQ-026 SHALL, without SERIAL_ADDER_OVERFLOW_EN, omit the V port and its capture logic, with all other behaviour identical.

Structure
REQ-027 SHALL take its state encoding (IDLE=0, RUN=1, DONE=2) and the 2-bit state width from shared package serial_adder_pkg.
REQ-028 SHALL instantiate exactly one full_adder sub-module (ports A, B, Cin, Cout, S) as the bit-slice datapath; no behavioral '+' SHALL be used for the sum.

Verification
REQ-029 SHALL cover: N=8, A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1, done exactly 9 cycles after start.
REQ-030 SHALL cover: N=8, A=8'h7F, B=8'h01, Cin=0 -> S=8'h80, Cout=0, V=1 with the macro defined; with A=8'h05, B=8'h03 -> S=8'h08, V=0.
REQ-031 SHALL cover: start pulsed on RUN cycle 3 with different operands -> ignored, and the original result returned on schedule.
REQ-032 SHALL cover: rst on RUN cycle 4 -> next cycle IDLE, all outputs 0, no done; a fresh start then completes correctly.
REQ-033 SHALL cover: start held high through DONE -> second operation begins with no IDLE cycle, giving a done pulse every N+1 cycles.
REQ-034 SHALL cover: N=4 exhaustive A, B, Cin (512 cases) -> {Cout,S} equals A+B+Cin in every case.
